// File: rtl/spi_burst_writer_if.sv
// spi_burst_writer_if: word handshake and SPI pin bundle for spi_burst_writer
interface spi_burst_writer_if #(
  parameter int DATA_W = 8,
  parameter int NUM_CS = 2
);
  localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
  logic [DATA_W-1:0] DATA;
  logic [CSW-1:0]    CS_SEL;
  logic              Hold_CS;
  logic              Start;
  logic              Ready;
  logic              MOSI;
  logic [NUM_CS-1:0] CS_N;
  logic              Running;
  logic              Done;
  modport master (output DATA, CS_SEL, Hold_CS, Start, input Ready, MOSI, CS_N, Running, Done);
  modport slave  (input DATA, CS_SEL, Hold_CS, Start, output Ready, MOSI, CS_N, Running, Done);
endinterface

// File: rtl/spi_burst_writer.sv
// spi_burst_writer: falling-edge SPI word writer with a one-deep buffer and held-CS bursts
module spi_burst_writer #(
  parameter int DATA_W    = 8,
  parameter int NUM_CS    = 2,
  parameter int CS_GAP    = 2,
  parameter int LSB_FIRST = 0
) (
  input logic             SCK,
  input logic             RST_N,
  spi_burst_writer_if.slave bus
);
  localparam int CSW = NUM_CS > 1 ? $clog2(NUM_CS) : 1;
  localparam int CW  = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [3:0]        gcnt_q, gcnt_d;
  logic [DATA_W-1:0] sh_q, sh_d;
  logic [CSW-1:0]    cur_cs_q, cur_cs_d;
  logic              cur_hold_q, cur_hold_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;
  logic              buf_v_q, buf_v_d;
  logic [DATA_W-1:0] buf_data_q, buf_data_d;
  logic [CSW-1:0]    buf_cs_q, buf_cs_d;
  logic              buf_hold_q, buf_hold_d;
  logic              acc, load_buf, load_in;
  // Selects outside 0..NUM_CS-1 match no line, so every CS_N stays high.
  function automatic logic [NUM_CS-1:0] cs_mask(input logic [CSW-1:0] s);
    cs_mask = '1;
    for (int i = 0; i < NUM_CS; i++) if (s == CSW'(i)) cs_mask[i] = 1'b0;
  endfunction
  assign acc = bus.Start & ready_q;
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    gcnt_d     = gcnt_q;
    sh_d       = sh_q;
    cur_cs_d   = cur_cs_q;
    cur_hold_d = cur_hold_q;
    cs_n_d     = cs_n_q;
    done_d     = 1'b0;
    buf_v_d    = buf_v_q;
    buf_data_d = buf_data_q;
    buf_cs_d   = buf_cs_q;
    buf_hold_d = buf_hold_q;
    load_buf   = 1'b0;
    load_in    = 1'b0;
    case (state_q)
      IDLE: begin
        load_buf = buf_v_q;
        load_in  = !buf_v_q && acc;
      end
      SHIFT: begin
        if (cnt_q == CW'(DATA_W - 1)) begin
          done_d = 1'b1;
          if (buf_v_q && cur_hold_q && buf_cs_q == cur_cs_q) load_buf = 1'b1;
          else begin
            state_d = GAP;
            gcnt_d  = '0;
            sh_d    = '0;
            cs_n_d  = '1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
          sh_d  = LSB_FIRST != 0 ? sh_q >> 1 : sh_q << 1;
        end
      end
      default: begin
        if (gcnt_q == 4'(CS_GAP - 1)) begin
          load_buf = buf_v_q;
          state_d  = IDLE;
        end else gcnt_d = gcnt_q + 4'd1;
      end
    endcase
    if (load_buf || load_in) begin
      state_d    = SHIFT;
      cnt_d      = '0;
      sh_d       = load_buf ? buf_data_q : bus.DATA;
      cur_cs_d   = load_buf ? buf_cs_q : bus.CS_SEL;
      cur_hold_d = load_buf ? buf_hold_q : bus.Hold_CS;
      cs_n_d     = cs_mask(load_buf ? buf_cs_q : bus.CS_SEL);
    end
    if (load_buf) buf_v_d = 1'b0;
    if (acc && !load_in) begin
      buf_v_d    = 1'b1;
      buf_data_d = bus.DATA;
      buf_cs_d   = bus.CS_SEL;
      buf_hold_d = bus.Hold_CS;
    end
    ready_d = !buf_v_d;
  end
  always_ff @(negedge SCK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      gcnt_q     <= '0;
      sh_q       <= '0;
      cur_cs_q   <= '0;
      cur_hold_q <= 1'b0;
      cs_n_q     <= '1;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      buf_v_q    <= 1'b0;
      buf_data_q <= '0;
      buf_cs_q   <= '0;
      buf_hold_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      gcnt_q     <= gcnt_d;
      sh_q       <= sh_d;
      cur_cs_q   <= cur_cs_d;
      cur_hold_q <= cur_hold_d;
      cs_n_q     <= cs_n_d;
      done_q     <= done_d;
      ready_q    <= ready_d;
      buf_v_q    <= buf_v_d;
      buf_data_q <= buf_data_d;
      buf_cs_q   <= buf_cs_d;
      buf_hold_q <= buf_hold_d;
    end
  end
  assign bus.MOSI    = LSB_FIRST != 0 ? sh_q[0] : sh_q[DATA_W-1];
  assign bus.CS_N    = cs_n_q;
  assign bus.Done    = done_q;
  assign bus.Ready   = ready_q;
  assign bus.Running = (state_q != IDLE) || buf_v_q;
endmodule

// File: tb/tb_spi_burst_writer.sv
// tb_spi_burst_writer: directed vectors for spi_burst_writer, MSB-first and LSB-first instances
module tb_spi_burst_writer;
  logic SCK = 1'b1;
  logic rst_n;
  int   nvec = 0, nbad = 0;
  always #5 SCK = ~SCK;
  spi_burst_writer_if #(.DATA_W(8), .NUM_CS(2)) bus ();
  spi_burst_writer_if #(.DATA_W(8), .NUM_CS(2)) bus2 ();
  assign bus2.Start   = bus.Start;
  assign bus2.DATA    = bus.DATA;
  assign bus2.CS_SEL  = bus.CS_SEL;
  assign bus2.Hold_CS = bus.Hold_CS;
  spi_burst_writer #(.DATA_W(8), .NUM_CS(2), .CS_GAP(2), .LSB_FIRST(0)) dut (.SCK(SCK), .RST_N(rst_n), .bus(bus.slave));
  spi_burst_writer #(.DATA_W(8), .NUM_CS(2), .CS_GAP(2), .LSB_FIRST(1)) dut2 (.SCK(SCK), .RST_N(rst_n), .bus(bus2.slave));
  typedef struct {
    logic       st;
    logic [7:0] d;
    logic       c, h, r;
    logic [6:0] exp;
  } vec_t;
  vec_t       tbl[13];
  logic       mo[24], dn[24], rd[24], rn_s[24];
  logic [1:0] cs[24];
  logic [7:0] sd[3];
  logic       sc[3], sh[3];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input logic st, input logic [7:0] d, input logic c, input logic h, input logic r);
    bus.Start = st;
    bus.DATA = d;
    bus.CS_SEL = c;
    bus.Hold_CS = h;
    rst_n = r;
    @(negedge SCK);
    @(posedge SCK);
  endtask
  task automatic seq(input int ns, input int rst_at);
    for (int i = 0; i < 24; i++) begin
      tick(i < ns, sd[i%3], sc[i%3], sh[i%3], i != rst_at);
      mo[i] = bus.MOSI;
      cs[i] = bus.CS_N;
      dn[i] = bus.Done;
      rd[i] = bus.Ready;
      rn_s[i] = bus.Running;
    end
  endtask
  function automatic logic [31:0] mbits(input int from, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[30:0], mo[from+i]};
    return r;
  endfunction
  function automatic logic [31:0] cbits(input int from, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r = {r[29:0], cs[from+i]};
    return r;
  endfunction
  function automatic logic [31:0] dmask();
    logic [31:0] r = '0;
    for (int i = 0; i < 24; i++) r[i] = dn[i];
    return r;
  endfunction
  initial begin
    bus.Start = 1'b0;
    bus.DATA = '0;
    bus.CS_SEL = '0;
    bus.Hold_CS = 1'b0;
    rst_n = 1'b0;
    // exp = {MOSI, MOSI(lsb-first), CS_N, Done, Ready, Running}
    tbl[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 7'b0_0_11_0_1_0};
    tbl[1] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 7'b0_1_10_0_1_1};
    for (int i = 2; i < 8; i++) tbl[i] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'b0_0_10_0_1_1};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'b1_0_10_0_1_1};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'b0_0_11_1_1_1};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'b0_0_11_0_1_1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'b0_0_11_0_1_0};
    tbl[12] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 7'b0_0_11_0_1_0};
    @(posedge SCK);
    tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 13; i++) begin
      tick(tbl[i].st, tbl[i].d, tbl[i].c, tbl[i].h, tbl[i].r);
      chk($sformatf("row%0d", i), 32'({bus.MOSI, bus2.MOSI, bus.CS_N, bus.Done, bus.Ready, bus.Running}), 32'(tbl[i].exp));
    end
    // held-CS burst on the same select
    sd = '{8'h3C, 8'hF0, 8'h00}; sc = '{1'b1, 1'b1, 1'b0}; sh = '{1'b1, 1'b0, 1'b0};
    seq(2, -1);
    chk("burst_mosi", mbits(0, 16), 32'h3CF0);
    chk("burst_cs", cbits(0, 16), 32'h5555_5555);
    chk("burst_done", dmask(), 32'h0001_0100);
    chk("burst_idle", 32'({rn_s[23], cs[23]}), 32'b0_11);
    // hold requested but the next word targets another select
    sd = '{8'h3C, 8'hF0, 8'h00}; sc = '{1'b1, 1'b0, 1'b0}; sh = '{1'b1, 1'b0, 1'b0};
    seq(2, -1);
    chk("switch_cs", cbits(0, 12), 32'h0055_55FA);
    chk("switch_mosi2", mbits(10, 8), 32'hF0);
    chk("switch_done", dmask(), 32'h0004_0100);
    // three Starts back to back: the third lands on Ready=0
    sd = '{8'hA5, 8'h5A, 8'hFF}; sc = '{1'b0, 1'b0, 1'b0}; sh = '{1'b1, 1'b0, 1'b1};
    seq(3, -1);
    chk("b2b_ready", 32'({rd[0], rd[1], rd[2], rd[7], rd[8]}), 32'b10001);
    chk("b2b_mosi", mbits(0, 24), 32'h00A5_5A00);
    chk("b2b_done", dmask(), 32'h0001_0100);
    chk("b2b_running", 32'({rn_s[15], rn_s[17], rn_s[18]}), 32'b110);
    // reset during bit 4 with a word buffered
    sd = '{8'h3C, 8'hF0, 8'h00}; sc = '{1'b0, 1'b0, 1'b0}; sh = '{1'b1, 1'b0, 1'b0};
    seq(2, 4);
    chk("rst_pre", 32'({rd[3], rn_s[3], cs[3]}), 32'b0_1_10);
    chk("rst_edge", 32'({mo[4], cs[4], rd[4], rn_s[4]}), 32'b0_11_1_0);
    chk("rst_nodone", dmask(), 32'h0);
    chk("rst_after", 32'({mbits(5, 19) == 0, rn_s[23], rd[23], cs[23]}), 32'b1_0_1_11);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
